// File: rtl/gf180mcu_osu_sc_clkdiv_pkg.sv
// Shared types and helpers for the 12T programmable clock divider.
package gf180mcu_osu_sc_clkdiv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int unsigned MIN_DIV = 2;

  // Ratios 0 and 1 cannot form a clock with both phases, so clamp to 2.
  function automatic int unsigned sanitise(input int unsigned div);
    return (div < MIN_DIV) ? MIN_DIV : div;
  endfunction

  function automatic int unsigned half_period(input int unsigned rat);
    return (rat + 32'd1) >> 1;
  endfunction

endpackage

// File: rtl/gf180mcu_osu_sc_clkdiv_cnt.sv
// Period counter: counts 0..RAT-1 while running, flags the wrap cycle.
module gf180mcu_osu_sc_clkdiv_cnt #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic [WIDTH-1:0] rat_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             tc_c_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  assign tc_c_o = run_i && (cnt_q == (rat_i - WIDTH'(1)));
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q + WIDTH'(1);
    if (!run_i || tc_c_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gf180mcu_osu_sc_12t_clkdiv.sv
// Glitch-free programmable clock divider with ratio load handshake.
// Define GF180MCU_OSU_SC_CLKDIV_EDGE_STROBE_EN to add RISE/FALL edge strobes.
module gf180mcu_osu_sc_12t_clkdiv
  import gf180mcu_osu_sc_clkdiv_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned RST_DIV = 2
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             EN,
  input  logic [WIDTH-1:0] DIV,
  input  logic             LOAD,
  output logic             Y,
  output logic             YN,
  output logic             BUSY,
  output logic             ACTIVE
`ifdef GF180MCU_OSU_SC_CLKDIV_EDGE_STROBE_EN
  ,
  output logic             RISE,
  output logic             FALL
`endif
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rat_q, rat_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             busy_q, busy_d;
  logic             y_q, y_d;
  logic             yn_q;
  logic             active_q;
  logic [WIDTH-1:0] cnt;
  logic             tc_c;
  logic [WIDTH-1:0] div_san_c;
  logic             high_c;

  gf180mcu_osu_sc_clkdiv_cnt #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk_i  (CLK),
    .rst_i  (R),
    .run_i  (state_q != IDLE),
    .rat_i  (rat_q),
    .cnt_o  (cnt),
    .tc_c_o (tc_c)
  );

  assign div_san_c = WIDTH'(sanitise(32'(DIV)));
  assign high_c    = (32'(cnt) + 32'd1) < half_period(32'(rat_q));

  // Next-state: ratio changes land only in IDLE or on the wrap edge.
  always_comb begin
    state_d = state_q;
    rat_d   = rat_q;
    pend_d  = pend_q;
    busy_d  = busy_q;
    y_d     = y_q;
    case (state_q)
      IDLE: begin
        y_d = 1'b0;
        if (LOAD) begin
          rat_d = div_san_c;
        end
        if (EN) begin
          state_d = RUN;
          y_d     = 1'b1;
        end
      end
      RUN, DRAIN: begin
        if (tc_c) begin
          busy_d = 1'b0;
          if (LOAD) begin
            rat_d = div_san_c;
          end else if (busy_q) begin
            rat_d = pend_q;
          end
          state_d = EN ? RUN : IDLE;
          y_d     = EN;
        end else begin
          y_d     = high_c;
          state_d = EN ? RUN : DRAIN;
          if (LOAD) begin
            pend_d = div_san_c;
            busy_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        y_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (R) begin
      state_q  <= IDLE;
      rat_q    <= WIDTH'(RST_DIV);
      pend_q   <= WIDTH'(RST_DIV);
      busy_q   <= 1'b0;
      y_q      <= 1'b0;
      yn_q     <= 1'b1;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rat_q    <= rat_d;
      pend_q   <= pend_d;
      busy_q   <= busy_d;
      y_q      <= y_d;
      yn_q     <= ~y_d;
      active_q <= (state_d != IDLE);
    end
  end

  assign Y      = y_q;
  assign YN     = yn_q;
  assign BUSY   = busy_q;
  assign ACTIVE = active_q;

`ifdef GF180MCU_OSU_SC_CLKDIV_EDGE_STROBE_EN
  logic rise_q;
  logic fall_q;

  // Strobes line up with the first cycle of each new Y phase.
  always_ff @(posedge CLK) begin
    if (R) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= y_d & ~y_q;
      fall_q <= ~y_d & y_q;
    end
  end

  assign RISE = rise_q;
  assign FALL = fall_q;
`endif

endmodule

// File: tb/tb_gf180mcu_osu_sc_12t_clkdiv.sv
// Self-checking bench: queue-based waveform model of the divider plus directed/random stimulus.
module tb_gf180mcu_osu_sc_12t_clkdiv;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned RST_DIV = 2;

  logic             CLK = 1'b0;
  logic             R = 1'b1;
  logic             EN = 1'b0;
  logic [WIDTH-1:0] DIV = '0;
  logic             LOAD = 1'b0;
  logic             Y, YN, BUSY, ACTIVE;
  logic [5:0]       obs;

  int checks = 0;
  int errors = 0;

`ifdef GF180MCU_OSU_SC_CLKDIV_EDGE_STROBE_EN
  logic RISE, FALL;
  assign obs = {Y, YN, BUSY, ACTIVE, RISE, FALL};
`else
  assign obs = {Y, YN, BUSY, ACTIVE, 2'b00};
`endif

  gf180mcu_osu_sc_12t_clkdiv #(
    .WIDTH   (WIDTH),
    .RST_DIV (RST_DIV)
  ) dut (
    .CLK    (CLK),
    .R      (R),
    .EN     (EN),
    .DIV    (DIV),
    .LOAD   (LOAD),
    .Y      (Y),
    .YN     (YN),
    .BUSY   (BUSY),
    .ACTIVE (ACTIVE)
`ifdef GF180MCU_OSU_SC_CLKDIV_EDGE_STROBE_EN
    ,
    .RISE   (RISE),
    .FALL   (FALL)
`endif
  );

  always #5 CLK = ~CLK;

  // Reference model: each period is a precomputed list of Y values that is
  // played out one bit per cycle; the period ends when the list runs dry.
  bit          m_act  = 1'b0;
  bit          m_y    = 1'b0;
  bit          m_yp   = 1'b0;
  bit          m_busy = 1'b0;
  int unsigned m_rat  = RST_DIV;
  int unsigned m_pend = RST_DIV;
  bit          m_wave[$];

  function automatic int unsigned m_san(input int unsigned d);
    return (d < 2) ? 2 : d;
  endfunction

  task automatic m_start();
    m_wave.delete();
    for (int unsigned i = 0; i < m_rat; i++) m_wave.push_back(i < (m_rat + 1) / 2);
    m_y   = m_wave.pop_front();
    m_act = 1'b1;
  endtask

  task automatic m_edge(input bit r, input bit en, input bit ld, input int unsigned d);
    m_yp = m_y;
    if (r) begin
      m_act = 1'b0; m_y = 1'b0; m_yp = 1'b0; m_busy = 1'b0;
      m_rat = RST_DIV; m_wave.delete();
    end else if (!m_act) begin
      if (ld) m_rat = m_san(d);
      if (en) m_start();
    end else if (m_wave.size() == 0) begin
      if (ld) m_rat = m_san(d);
      else if (m_busy) m_rat = m_pend;
      m_busy = 1'b0;
      if (en) m_start();
      else begin m_act = 1'b0; m_y = 1'b0; end
    end else begin
      m_y = m_wave.pop_front();
      if (ld) begin m_pend = m_san(d); m_busy = 1'b1; end
    end
  endtask

  function automatic logic [5:0] m_exp();
`ifdef GF180MCU_OSU_SC_CLKDIV_EDGE_STROBE_EN
    return {m_y, ~m_y, m_busy, m_act, m_y & ~m_yp, ~m_y & m_yp};
`else
    return {m_y, ~m_y, m_busy, m_act, 2'b00};
`endif
  endfunction

  task automatic tick(input bit r, input bit en, input bit ld, input logic [WIDTH-1:0] d);
    R = r; EN = en; LOAD = ld; DIV = d;
    @(posedge CLK);
    m_edge(r, en, ld, int'(d));
    #1;
  endtask

  // Drop EN and let any period in flight finish.
  task automatic wind_down();
    int n = 0;
    while (m_act && n < 300) begin
      tick(1'b0, 1'b0, 1'b0, '0);
      checks++;
      if (obs !== m_exp()) begin
        errors++;
        $display("FAIL wind_down n=%0d got %b exp %b", n, obs, m_exp());
      end
      n++;
    end
    checks++;
    if (m_act || ACTIVE !== 1'b0) begin
      errors++;
      $display("FAIL wind_down_idle active got %b exp 0", ACTIVE);
    end
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1, 1'b1, 8'd9);
    tick(1'b1, 1'b0, 1'b0, '0);
    checks++;
    if (obs !== 6'b010000 || obs !== m_exp()) begin
      errors++;
      $display("FAIL reset got %b exp %b", obs, 6'b010000);
    end
  endtask

  task automatic test_div2();
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b1, 1'b0, '0);
      checks++;
      if (obs !== m_exp() || Y !== ((i % 2) == 0)) begin
        errors++;
        $display("FAIL div2 cyc=%0d got %b exp %b", i, obs, m_exp());
      end
    end
    wind_down();
  endtask

  task automatic test_load_idle();
    tick(1'b0, 1'b0, 1'b1, 8'd5);
    for (int i = 0; i < 15; i++) begin
      tick(1'b0, 1'b1, 1'b0, '0);
      checks++;
      if (obs !== m_exp() || Y !== ((i % 5) < 3) || ACTIVE !== 1'b1) begin
        errors++;
        $display("FAIL load_idle cyc=%0d got %b exp %b", i, obs, m_exp());
      end
    end
    wind_down();
  endtask

  task automatic test_load_running();
    logic [6:0] want;
    tick(1'b0, 1'b0, 1'b1, 8'd4);
    tick(1'b0, 1'b1, 1'b0, '0);
    tick(1'b0, 1'b1, 1'b0, '0);
    tick(1'b0, 1'b1, 1'b1, 8'd7);
    checks++;
    if (BUSY !== 1'b1 || obs !== m_exp()) begin
      errors++;
      $display("FAIL load_run_busy got %b exp %b", obs, m_exp());
    end
    tick(1'b0, 1'b1, 1'b0, '0);
    want = 7'b1111000;
    for (int i = 0; i < 7; i++) begin
      tick(1'b0, 1'b1, 1'b0, '0);
      checks++;
      if (obs !== m_exp() || Y !== want[6 - i] || BUSY !== 1'b0) begin
        errors++;
        $display("FAIL load_run_new cyc=%0d got %b exp %b", i, obs, m_exp());
      end
    end
    wind_down();
  endtask

  task automatic test_drain();
    for (int pass = 0; pass < 2; pass++) begin
      tick(1'b0, 1'b0, 1'b1, 8'd6);
      tick(1'b0, 1'b1, 1'b0, '0);
      tick(1'b0, 1'b1, 1'b0, '0);
      for (int i = 0; i < 12; i++) begin
        tick(1'b0, (pass == 1) && (i >= 2), 1'b0, '0);
        checks++;
        if (obs !== m_exp()) begin
          errors++;
          $display("FAIL drain pass=%0d cyc=%0d got %b exp %b", pass, i, obs, m_exp());
        end
      end
      wind_down();
    end
  endtask

  task automatic test_last_wins();
    tick(1'b0, 1'b0, 1'b1, 8'd3);
    tick(1'b0, 1'b1, 1'b0, '0);
    tick(1'b0, 1'b1, 1'b1, 8'd0);
    tick(1'b0, 1'b1, 1'b1, 8'd1);
    tick(1'b0, 1'b1, 1'b1, 8'd9);
    for (int i = 0; i < 30; i++) begin
      tick(1'b0, 1'b1, (i == 12), 8'd1);
      checks++;
      if (obs !== m_exp()) begin
        errors++;
        $display("FAIL last_wins cyc=%0d got %b exp %b", i, obs, m_exp());
      end
    end
    wind_down();
  endtask

  task automatic test_reset_mid();
    tick(1'b0, 1'b0, 1'b1, 8'd8);
    tick(1'b0, 1'b1, 1'b0, '0);
    tick(1'b0, 1'b1, 1'b1, 8'd5);
    tick(1'b0, 1'b1, 1'b0, '0);
    tick(1'b1, 1'b1, 1'b0, '0);
    checks++;
    if (obs !== 6'b010000 || obs !== m_exp()) begin
      errors++;
      $display("FAIL reset_mid got %b exp %b", obs, 6'b010000);
    end
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b1, 1'b0, '0);
      checks++;
      if (obs !== m_exp() || Y !== ((i % 2) == 0)) begin
        errors++;
        $display("FAIL reset_mid_rst_div cyc=%0d got %b exp %b", i, obs, m_exp());
      end
    end
    wind_down();
  endtask

  task automatic test_random();
    bit r, en, ld;
    logic [WIDTH-1:0] d;
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      en = ($urandom_range(0, 9) != 0);
      ld = ($urandom_range(0, 7) == 0);
      d  = ($urandom_range(0, 9) == 0) ? WIDTH'($urandom_range(0, 255))
                                       : WIDTH'($urandom_range(0, 12));
      tick(r, en, ld, d);
      checks++;
      if (obs !== m_exp()) begin
        errors++;
        $display("FAIL random cyc=%0d got %b exp %b", i, obs, m_exp());
      end
    end
    wind_down();
  endtask

  initial begin
    test_reset();
    test_div2();
    test_load_idle();
    test_load_running();
    test_drain();
    test_last_wins();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
